mips_cpu_wb_arbiter: RTL
========================

# mips_cpu_wb_arbiter

Write-back arbiter and register scoreboard in front of the `regfile` write port. It shares the single write port between two requesters: the execute stage (ALU results) and the load unit (memory data). It forwards the load opcode so the register file can do partial-load formatting. It also tracks destination registers that have been issued but not yet written, so the decoder can stall on read-after-write hazards.

## Interface
Parameters:
- `NREG`, 32: number of architectural registers; the index width is log2(NREG).

Ports:
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `ex_valid`  in  1: execute-stage write request.
- `ex_ready`  out  1: execute request accepted this edge when `ex_valid & ex_ready`.
- `ex_reg`  in  5: execute destination register.
- `ex_data`  in  32: execute result.
- `ld_valid`  in  1: load-unit write request.
- `ld_ready`  out  1: load-unit request accepted when `ld_valid & ld_ready`.
- `ld_reg`  in  5: load destination register.
- `ld_data`  in  32: raw load word.
- `ld_opcode`  in  6: load opcode (lb/lbu/lh/lhu/lwl/lwr/lw).
- `claim_valid`  in  1: decoder issues an instruction that will write `claim_reg`.
- `claim_reg`  in  5: register being claimed.
- `chk_rs`  in  5: decoder source register 1.
- `chk_rt`  in  5: decoder source register 2.
- `hazard`  out  1: combinational; `pending[chk_rs] | pending[chk_rt]`.
- `regwrite`  out  1: to the regfile enable.
- `writereg`  out  5: to the regfile.
- `writedata`  out  32: to the regfile.
- `opcode`  out  6: to the regfile partial-load control.
- `pending`  out  32: scoreboard bit vector, for debug.

## Operation
- Each requester owns a one-entry slot holding reg, data and opcode. The execute slot's opcode is forced to 6'b000000 (full-word write).
- `x_ready = !slot_full | slot_granted_this_cycle`. A single-cycle pass-through is allowed: a new request can be accepted into a slot on the same edge that slot's entry is granted out.
- Arbitration happens every cycle among full slots:
  - If only one slot is full, that slot is granted.
  - If both are full, grant round-robin: the slot not granted last time wins. `last_grant` resets to EX, so LD wins the first conflict.
- A granted entry is loaded into the output registers `regwrite`/`writereg`/`writedata`/`opcode`.
- If nothing is granted, `regwrite` = 0. `writereg`, `writedata` and `opcode` hold their previous values.
- Register 0:
  - Entries with reg 0 are accepted and consumed, but drive `regwrite` = 0.
  - A claim of reg 0 never sets its pending bit; `pending[0]` is always 0.
- Scoreboard:
  - `claim_valid` sets `pending[claim_reg]`.
  - A grant clears `pending[granted reg]`.
  - If a claim and a clear hit the same register on the same edge, the set wins (a newer instruction owns it).
  - Granting a register that is not pending is legal; it is written and the bit stays 0.
- `hazard` reads the registered `pending` vector only. There is no same-cycle bypass from the grant.

## Timing
- Reset values:
  - `regwrite`, `writereg`, `writedata`, `opcode`, `pending` = 0.
  - Both slots empty.
  - `ex_ready` = `ld_ready` = 1.
  - `last_grant` = EX.
- Latency:
  - Accept at edge N places the request in its slot.
  - Grant at edge N+1 at the earliest, so `regwrite` is high during cycle N+1 → N+2.
  - The regfile captures the write on the falling edge inside that cycle.
- Throughput: one write per cycle in total. Under sustained contention each requester gets one write every 2 cycles.
- `ready` depends on slot state and the arbiter grant only, never on the same requester's `valid`.
- Reset mid-operation:
  - Slot contents and pending bits are discarded immediately, with no write.
  - `regwrite` drops asynchronously.

## Structure
- Shared package `mips_cpu_wb_pkg`:
  - Opcode localparams (LB, LBU, LH, LHU, LWL, LWR, LW, OP_RTYPE).
  - Typedef `wb_req_t` {reg, data, opcode}.
  - Enum `wb_src_e` {SRC_EX, SRC_LD}.
- Sub-module `mips_cpu_wb_slot`: a one-entry buffer with valid/ready in and a grant/clear out, instantiated twice.
- The arbiter, output registers and scoreboard live in the top level.

## Test plan
- Reset, then a single EX request (reg 5, data 0xDEADBEEF) → `regwrite` = 1 one cycle after accept, `writereg` = 5, `opcode` = 0; `pending[5]` clears if it was claimed.
- EX (reg 3) and LD (reg 4, opcode 100000) valid together and held → grants in the order LD, EX, LD, EX…; each requester sees `ready` = 0 on alternate cycles; no request is lost.
- `claim_reg` = 7, then `chk_rs` = 7 → `hazard` = 1 until the edge where reg 7 is granted; `hazard` = 0 the following cycle.
- Claim of reg 9 and a grant of reg 9 on the same edge → `pending[9]` stays 1.
- Request to reg 0 and a claim of reg 0 → `regwrite` stays 0; `pending[0]` = 0.
- Assert `reset` while both slots are full → outputs go to 0 immediately; no write appears after reset is released.

Source files
------------

// File: rtl/mips_cpu_wb_pkg.sv
// rtl/mips_cpu_wb_pkg.sv - shared types and constants for the write-back arbiter
package mips_cpu_wb_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    // Load opcodes forwarded to the regfile for partial-load formatting
    localparam logic [OP_W-1:0] LB       = 6'b100000;
    localparam logic [OP_W-1:0] LH       = 6'b100001;
    localparam logic [OP_W-1:0] LWL      = 6'b100010;
    localparam logic [OP_W-1:0] LW       = 6'b100011;
    localparam logic [OP_W-1:0] LBU      = 6'b100100;
    localparam logic [OP_W-1:0] LHU      = 6'b100101;
    localparam logic [OP_W-1:0] LWR      = 6'b100110;
    // Full-word write, used for every execute-stage result
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;

    typedef struct packed {
        logic [REG_W-1:0]  regnum;
        logic [DATA_W-1:0] data;
        logic [OP_W-1:0]   opcode;
    } wb_req_t;

    typedef enum logic {
        SRC_EX = 1'b0,
        SRC_LD = 1'b1
    } wb_src_e;

endpackage

// File: rtl/mips_cpu_wb_arbiter_if.sv
// rtl/mips_cpu_wb_arbiter_if.sv - requester, decoder and regfile signals of the write-back arbiter
interface mips_cpu_wb_arbiter_if;
    import mips_cpu_wb_pkg::*;

    logic              ex_valid;
    logic              ex_ready;
    logic [REG_W-1:0]  ex_reg;
    logic [DATA_W-1:0] ex_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [REG_W-1:0]  ld_reg;
    logic [DATA_W-1:0] ld_data;
    logic [OP_W-1:0]   ld_opcode;

    logic              claim_valid;
    logic [REG_W-1:0]  claim_reg;
    logic [REG_W-1:0]  chk_rs;
    logic [REG_W-1:0]  chk_rt;
    logic              hazard;

    logic              regwrite;
    logic [REG_W-1:0]  writereg;
    logic [DATA_W-1:0] writedata;
    logic [OP_W-1:0]   opcode;
    logic [31:0]       pending;

    // Driver side: pipeline stages and decoder
    modport master (
        output ex_valid, ex_reg, ex_data,
        output ld_valid, ld_reg, ld_data, ld_opcode,
        output claim_valid, claim_reg, chk_rs, chk_rt,
        input  ex_ready, ld_ready, hazard,
        input  regwrite, writereg, writedata, opcode, pending
    );

    // Arbiter side
    modport slave (
        input  ex_valid, ex_reg, ex_data,
        input  ld_valid, ld_reg, ld_data, ld_opcode,
        input  claim_valid, claim_reg, chk_rs, chk_rt,
        output ex_ready, ld_ready, hazard,
        output regwrite, writereg, writedata, opcode, pending
    );

endinterface

// File: rtl/mips_cpu_wb_slot.sv
// rtl/mips_cpu_wb_slot.sv - one-entry write request buffer with same-edge pass-through
module mips_cpu_wb_slot
    import mips_cpu_wb_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    in_valid,
    output logic    in_ready,
    input  wb_req_t in_req,
    output logic    full,
    output wb_req_t q,
    input  logic    grant
);

    // A granted entry leaves on this edge, so its space can be refilled at once
    assign in_ready = !full || grant;

    // Slot occupancy and contents; a new accept takes priority over the drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            q    <= '0;
        end else if (in_valid && in_ready) begin
            full <= 1'b1;
            q    <= in_req;
        end else if (grant) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/mips_cpu_wb_arbiter.sv
// rtl/mips_cpu_wb_arbiter.sv - shares the regfile write port between execute and load, tracks pending writes
module mips_cpu_wb_arbiter
    import mips_cpu_wb_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mips_cpu_wb_arbiter_if.slave bus
);

    localparam int IW = $clog2(NREG);

    wb_req_t   ex_in, ld_in, ex_q, ld_q, win;
    logic      ex_full, ld_full;
    logic      grant_ex, grant_ld, any_grant;
    wb_src_e   last_grant;
    logic [NREG-1:0] pend, pend_nxt;

    assign ex_in = '{regnum: bus.ex_reg, data: bus.ex_data, opcode: OP_RTYPE};
    assign ld_in = '{regnum: bus.ld_reg, data: bus.ld_data, opcode: bus.ld_opcode};

    mips_cpu_wb_slot u_ex_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.ex_valid),
        .in_ready (bus.ex_ready),
        .in_req   (ex_in),
        .full     (ex_full),
        .q        (ex_q),
        .grant    (grant_ex)
    );

    mips_cpu_wb_slot u_ld_slot (
        .clk      (clk),
        .reset    (reset),
        .in_valid (bus.ld_valid),
        .in_ready (bus.ld_ready),
        .in_req   (ld_in),
        .full     (ld_full),
        .q        (ld_q),
        .grant    (grant_ld)
    );

    // Grant depends on slot occupancy only, so ready never loops back through valid
    always_comb begin
        grant_ex = 1'b0;
        grant_ld = 1'b0;
        if (ex_full && ld_full) begin
            if (last_grant == SRC_EX) grant_ld = 1'b1;
            else                      grant_ex = 1'b1;
        end else begin
            grant_ex = ex_full;
            grant_ld = ld_full;
        end
    end

    assign any_grant = grant_ex || grant_ld;
    assign win       = grant_ld ? ld_q : ex_q;

    // Remember the last winner so contention alternates
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         last_grant <= SRC_EX;
        else if (grant_ld) last_grant <= SRC_LD;
        else if (grant_ex) last_grant <= SRC_EX;
    end

    // Regfile-facing registers; reg 0 entries are consumed without a write strobe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.regwrite  <= 1'b0;
            bus.writereg  <= '0;
            bus.writedata <= '0;
            bus.opcode    <= '0;
        end else if (any_grant) begin
            bus.regwrite  <= (win.regnum != '0);
            bus.writereg  <= win.regnum;
            bus.writedata <= win.data;
            bus.opcode    <= win.opcode;
        end else begin
            bus.regwrite  <= 1'b0;
        end
    end

    // Scoreboard update: a claim overrides a same-edge clear, reg 0 is never pending
    always_comb begin
        pend_nxt = pend;
        if (any_grant)       pend_nxt[win.regnum[IW-1:0]] = 1'b0;
        if (bus.claim_valid) pend_nxt[bus.claim_reg[IW-1:0]] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    // Scoreboard register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend <= '0;
        else       pend <= pend_nxt;
    end

    assign bus.pending = pend;
    assign bus.hazard  = pend[bus.chk_rs[IW-1:0]] || pend[bus.chk_rt[IW-1:0]];

endmodule
